plot_ctrl: RTL and testbench



---
 rtl/plot_ctrl.sv | 160 ++++++++++++++++
 tb/tb_plot_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_ctrl.sv
// Control FSM for the VGA square plotter: loads X/Y via the go handshake, then draws a 4x4 square or clears the screen.
// Optional build macro PLOT_CTRL_CLIP_EN suppresses writeEn for off-screen pixels during a square draw.
module plot_ctrl #(
  parameter int SQ_LOG2  = 2,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       plot,
  input  logic       black,
  input  logic [6:0] data_in,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       writeEn,
  output logic       busy,
  output logic       done
);

  localparam int CW = 2 * SQ_LOG2;
  localparam logic [7:0] W_LIM  = 8'(SCREEN_W);
  localparam logic [6:0] H_LIM  = 7'(SCREEN_H);
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
`ifdef PLOT_CTRL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_LOAD_X,
    S_LOAD_X_WAIT,
    S_LOAD_Y,
    S_LOAD_Y_WAIT,
    S_READY,
    S_DRAW,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t        state;
  logic [7:0]    x_reg;
  logic [6:0]    y_reg;
  logic [2:0]    col_reg;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [7:0]    cx;
  logic [6:0]    cy;
  logic          black_ok;

  function automatic logic [7:0] px_x(input logic [7:0] xr, input logic [CW-1:0] c);
    return xr + 8'(c[SQ_LOG2-1:0]);
  endfunction

  function automatic logic [6:0] px_y(input logic [6:0] yr, input logic [CW-1:0] c);
    return yr + 7'(c[CW-1:SQ_LOG2]);
  endfunction

  function automatic logic pix_we(input logic [7:0] xo, input logic [6:0] yo);
    return !CLIP_EN || ((xo < W_LIM) && (yo < H_LIM));
  endfunction

  always_comb begin
    cnt_nxt  = cnt + 1'b1;
    black_ok = black && (state != S_DRAW) && (state != S_CLEAR) && (state != S_DONE);
  end

  // Outputs are registered one step ahead, so each edge loads the pixel for the next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_LOAD_X;
      x_reg      <= '0;
      y_reg      <= '0;
      col_reg    <= '0;
      cnt        <= '0;
      cx         <= '0;
      cy         <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      writeEn    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (black_ok) begin
        state      <= S_CLEAR;
        cx         <= '0;
        cy         <= '0;
        x_out      <= '0;
        y_out      <= '0;
        colour_out <= '0;
        writeEn    <= 1'b1;
        busy       <= 1'b1;
      end else begin
        case (state)
          S_LOAD_X: if (go) begin
            x_reg <= {1'b0, data_in};
            state <= S_LOAD_X_WAIT;
          end
          S_LOAD_X_WAIT: if (!go) state <= S_LOAD_Y;
          S_LOAD_Y: if (go) begin
            y_reg <= data_in;
            state <= S_LOAD_Y_WAIT;
          end
          S_LOAD_Y_WAIT: if (!go) state <= S_READY;
          S_READY: if (plot) begin
            col_reg    <= colour_in;
            cnt        <= '0;
            x_out      <= x_reg;
            y_out      <= y_reg;
            colour_out <= colour_in;
            writeEn    <= pix_we(x_reg, y_reg);
            busy       <= 1'b1;
            state      <= S_DRAW;
          end
          S_DRAW: begin
            if (cnt == '1) begin
              writeEn <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              cnt        <= cnt_nxt;
              x_out      <= px_x(x_reg, cnt_nxt);
              y_out      <= px_y(y_reg, cnt_nxt);
              colour_out <= col_reg;
              writeEn    <= pix_we(px_x(x_reg, cnt_nxt), px_y(y_reg, cnt_nxt));
            end
          end
          S_CLEAR: begin
            if (cx == X_LAST) begin
              if (cy == Y_LAST) begin
                writeEn <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= S_DONE;
              end else begin
                cx    <= '0;
                cy    <= cy + 1'b1;
                x_out <= '0;
                y_out <= cy + 1'b1;
              end
            end else begin
              cx    <= cx + 1'b1;
              x_out <= cx + 1'b1;
            end
          end
          S_DONE:  state <= S_LOAD_X;
          default: state <= S_LOAD_X;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plot_ctrl.sv
// Scoreboard bench for plot_ctrl: stimulus pushes expected pixel writes and done pulses, a monitor pops and compares.
module tb_plot_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic       plot = 1'b0;
  logic       black = 1'b0;
  logic [6:0] data_in = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       writeEn;
  logic       busy;
  logic       done;

  plot_ctrl #(.SQ_LOG2(2), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .resetn(resetn), .go(go), .plot(plot), .black(black),
    .data_in(data_in), .colour_in(colour_in), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .writeEn(writeEn), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

`ifdef PLOT_CTRL_CLIP_EN
  localparam bit CLIP_MODE = 1'b1;
`else
  localparam bit CLIP_MODE = 1'b0;
`endif

  typedef struct packed {
    logic       is_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned mx, my;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit visible(input int unsigned x, input int unsigned y);
    return !CLIP_MODE || (x < 160 && y < 120);
  endfunction

  // Reference: the first n pixels of a row-major 4x4 square, y wrapping at 128.
  task automatic model_square(input int unsigned x, input int unsigned y, input int unsigned c,
                              input int unsigned n);
    ev_t e;
    for (int unsigned i = 0; i < n && i < 16; i++) begin
      int unsigned xo = x + (i % 4);
      int unsigned yo = (y + i / 4) % 128;
      if (visible(xo, yo)) begin
        e = '{is_done: 1'b0, x: 8'(xo), y: 7'(yo), c: 3'(c)};
        exp_q.push_back(e);
      end
    end
    if (n == 16) begin
      e = '{is_done: 1'b1, x: 8'd0, y: 7'd0, c: 3'd0};
      exp_q.push_back(e);
    end
  endtask

  task automatic model_clear();
    ev_t e;
    for (int unsigned yy = 0; yy < 120; yy++)
      for (int unsigned xx = 0; xx < 160; xx++) begin
        e = '{is_done: 1'b0, x: 8'(xx), y: 7'(yy), c: 3'd0};
        exp_q.push_back(e);
      end
    e = '{is_done: 1'b1, x: 8'd0, y: 7'd0, c: 3'd0};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (writeEn) begin
      chk("busy_with_write", busy == 1'b1, 32'(busy), 32'd1);
      if (exp_q.size() == 0)
        chk("unexpected_write", 1'b0, {14'd0, x_out, y_out, colour_out}, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("pixel", !mon_e.is_done && x_out == mon_e.x && y_out == mon_e.y && colour_out == mon_e.c,
            {14'd0, x_out, y_out, colour_out}, {13'd0, mon_e});
      end
    end
    if (done) begin
      if (exp_q.size() == 0)
        chk("unexpected_done", 1'b0, 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("done_pulse", mon_e.is_done == 1'b1, 32'd1, {13'd0, mon_e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_coord(input int unsigned v, input int unsigned hold);
    go = 1'b1;
    data_in = 7'(v);
    tick();
    for (int unsigned i = 1; i < hold; i++) begin
      data_in = 7'($urandom);
      tick();
    end
    go = 1'b0;
    data_in = 7'($urandom);
    tick();
  endtask

  task automatic load_xy(input int unsigned x, input int unsigned y, input int unsigned hold);
    load_coord(x, hold);
    mx = x;
    load_coord(y, hold);
    my = y;
  endtask

  task automatic wait_done(output int unsigned k, input int unsigned limit);
    k = 0;
    while (!done && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic do_plot(input int unsigned c);
    int unsigned k;
    colour_in = 3'(c);
    plot = 1'b1;
    model_square(mx, my, c, 16);
    tick();
    chk("first_write_latency", writeEn == visible(mx, my), 32'(writeEn), 32'(visible(mx, my)));
    chk("busy_in_draw", busy == 1'b1, 32'(busy), 32'd1);
    wait_done(k, 40);
    chk("draw_length", k == 16, k, 32'd16);
    repeat (4) tick();
    plot = 1'b0;
    tick();
  endtask

  task automatic do_black(input bit with_plot);
    int unsigned k;
    black = 1'b1;
    plot = with_plot;
    colour_in = 3'($urandom);
    model_clear();
    tick();
    black = 1'b0;
    plot = 1'b0;
    chk("busy_in_clear", busy == 1'b1, 32'(busy), 32'd1);
    wait_done(k, 20000);
    chk("clear_length", k == 19200, k, 32'd19200);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_x_out"}, x_out == 8'd0, 32'(x_out), 32'd0);
    chk({tag, "_y_out"}, y_out == 7'd0, 32'(y_out), 32'd0);
    chk({tag, "_colour_out"}, colour_out == 3'd0, 32'(colour_out), 32'd0);
    chk({tag, "_writeEn"}, writeEn == 1'b0, 32'(writeEn), 32'd0);
    chk({tag, "_busy"}, busy == 1'b0, 32'(busy), 32'd0);
    chk({tag, "_done"}, done == 1'b0, 32'(done), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();

    // plot must be ignored before coordinates are loaded
    plot = 1'b1;
    repeat (3) tick();
    plot = 1'b0;
    load_coord(10, 5);
    mx = 10;
    plot = 1'b1;
    repeat (2) tick();
    plot = 1'b0;
    load_coord(20, 2);
    my = 20;
    do_plot(4);

    load_xy(126, 118, 1);
    do_plot($urandom_range(7, 0));
    load_xy(5, 126, 3);
    do_plot($urandom_range(7, 0));

    repeat (6) begin
      load_xy($urandom_range(127, 0), $urandom_range(127, 0), $urandom_range(4, 1));
      do_plot($urandom_range(7, 0));
    end

    load_coord($urandom_range(127, 0), 2);
    do_black(1'b0);

    load_xy($urandom_range(127, 0), $urandom_range(127, 0), 1);
    do_black(1'b1);

    // abort a draw with reset while cycle 7 is on the outputs
    load_xy(40, 50, 2);
    colour_in = 3'd6;
    plot = 1'b1;
    model_square(40, 50, 6, 8);
    tick();
    plot = 1'b0;
    repeat (7) tick();
    resetn = 1'b0;
    tick();
    check_reset_outputs("abort");
    resetn = 1'b1;
    repeat (3) tick();
    chk("abort_no_write", writeEn == 1'b0, 32'(writeEn), 32'd0);

    load_xy(100, 7, 2);
    do_plot(2);

    repeat (5) tick();
    chk("queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
